// File: rtl/spi_bridge_if.sv
// SPI pins plus the byte-level decoder handshake carried by spi_bridge.
// slave = bridge side, master = SPI master / decoder side.
interface spi_bridge_if;
   logic       sclk;
   logic       cs_n;
   logic       mosi;
   logic       miso;
   logic       byte_sync;
   logic [7:0] data_in;
   logic [7:0] data_out;
   logic       busy;
   logic       frame_err;

   modport slave (
      input  sclk, cs_n, mosi, data_out,
      output miso, byte_sync, data_in, busy, frame_err
   );

   modport master (
      output sclk, cs_n, mosi, data_out,
      input  miso, byte_sync, data_in, busy, frame_err
   );
endinterface

// File: rtl/spi_bridge.sv
// SPI mode-0 slave, MSB first, oversampled in the clk domain. Delivers received bytes
// to the decoder with a byte_sync strobe and shifts the decoder's data_out onto miso.
module spi_bridge #(
   parameter int   SYNC_STAGES = 2,
   parameter logic IDLE_MISO   = 1'b0
) (
   input logic        clk,
   input logic        rst,
   spi_bridge_if.slave bus
);

   typedef enum logic {IDLE, ACTIVE} state_e;

   state_e                 state_q, state_d;
   logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
   logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
   logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
   logic                   sclk_prev_q, sclk_prev_d;
   logic [7:0]             rx_sr_q, rx_sr_d;
   logic [7:0]             tx_sr_q, tx_sr_d;
   logic [7:0]             data_in_q, data_in_d;
   logic [2:0]             bit_cnt_q, bit_cnt_d;
   logic                   byte_sync_q, byte_sync_d;
   logic                   reload_q, reload_d;
   logic                   busy_q, busy_d;
   logic                   frame_err_q, frame_err_d;

   logic sclk_s, cs_s, mosi_s, rise, fall;

   assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
   assign cs_s   = cs_sync_q[SYNC_STAGES-1];
   assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
   assign rise   = sclk_s & ~sclk_prev_q;
   assign fall   = ~sclk_s & sclk_prev_q;

   always_comb begin
      sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], bus.sclk};
      cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], bus.cs_n};
      mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], bus.mosi};
      sclk_prev_d = sclk_s;
   end

   always_comb begin
      state_d     = state_q;
      rx_sr_d     = rx_sr_q;
      tx_sr_d     = tx_sr_q;
      data_in_d   = data_in_q;
      bit_cnt_d   = bit_cnt_q;
      busy_d      = busy_q;
      byte_sync_d = 1'b0;
      frame_err_d = 1'b0;
      // data_out is re-sampled one cycle after byte_sync so a decoder reacting to the strobe is seen
      reload_d    = byte_sync_q;
      case (state_q)
         IDLE: begin
            if (!cs_s) begin
               state_d   = ACTIVE;
               tx_sr_d   = bus.data_out;
               bit_cnt_d = 3'd0;
               busy_d    = 1'b1;
            end
         end
         ACTIVE: begin
            if (cs_s) begin
               // release dominates any coincident sclk edge
               state_d     = IDLE;
               busy_d      = 1'b0;
               frame_err_d = (bit_cnt_q != 3'd0);
               rx_sr_d     = 8'd0;
               bit_cnt_d   = 3'd0;
            end else begin
               if (rise) begin
                  rx_sr_d   = {rx_sr_q[6:0], mosi_s};
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'd7) begin
                     data_in_d   = {rx_sr_q[6:0], mosi_s};
                     byte_sync_d = 1'b1;
                  end
               end
               if (reload_q)
                  tx_sr_d = bus.data_out;
               else if (fall && bit_cnt_q != 3'd0)
                  tx_sr_d = {tx_sr_q[6:0], 1'b0};
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         sclk_sync_q <= '0;
         cs_sync_q   <= '1;
         mosi_sync_q <= '0;
         sclk_prev_q <= 1'b0;
         rx_sr_q     <= 8'd0;
         tx_sr_q     <= 8'd0;
         data_in_q   <= 8'd0;
         bit_cnt_q   <= 3'd0;
         byte_sync_q <= 1'b0;
         reload_q    <= 1'b0;
         busy_q      <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         sclk_sync_q <= sclk_sync_d;
         cs_sync_q   <= cs_sync_d;
         mosi_sync_q <= mosi_sync_d;
         sclk_prev_q <= sclk_prev_d;
         rx_sr_q     <= rx_sr_d;
         tx_sr_q     <= tx_sr_d;
         data_in_q   <= data_in_d;
         bit_cnt_q   <= bit_cnt_d;
         byte_sync_q <= byte_sync_d;
         reload_q    <= reload_d;
         busy_q      <= busy_d;
         frame_err_q <= frame_err_d;
      end
   end

   assign bus.miso      = (state_q == ACTIVE) ? tx_sr_q[7] : IDLE_MISO;
   assign bus.byte_sync = byte_sync_q;
   assign bus.data_in   = data_in_q;
   assign bus.busy      = busy_q;
   assign bus.frame_err = frame_err_q;

endmodule
